// File: rtl/kianv_mem_arbiter_rr.sv
// Round-robin arbiter letting several kianv native-bus masters share one slave port.
// A bus watchdog completes a hung slave transaction with access_fault to the owner.
module kianv_mem_arbiter_rr #(
  parameter int NUM_MASTERS    = 2,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255,
  localparam int WS = DATA_WIDTH / 8,
  localparam int GW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_MASTERS-1:0]            m_valid,
  output logic [NUM_MASTERS-1:0]            m_ready,
  input  logic [WS*NUM_MASTERS-1:0]         m_wstrb,
  input  logic [ADDR_WIDTH*NUM_MASTERS-1:0] m_addr,
  input  logic [DATA_WIDTH*NUM_MASTERS-1:0] m_wdata,
  output logic [DATA_WIDTH-1:0]             m_rdata,
  output logic [NUM_MASTERS-1:0]            m_access_fault,
  output logic                              s_valid,
  input  logic                              s_ready,
  output logic [WS-1:0]                     s_wstrb,
  output logic [ADDR_WIDTH-1:0]             s_addr,
  output logic [DATA_WIDTH-1:0]             s_wdata,
  input  logic [DATA_WIDTH-1:0]             s_rdata,
  input  logic                              s_access_fault,
  output logic [GW-1:0]                     grant,
  output logic                              busy
);

  localparam int WDW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [WDW-1:0] WDOG_MAX  = WDW'(TIMEOUT_CYCLES);
  localparam logic [GW-1:0]  LAST_INIT = GW'(NUM_MASTERS - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state_reg;
  logic [GW-1:0]   grant_reg;
  logic [GW-1:0]   last_reg;
  logic [WDW-1:0]  wdog_reg;

  logic [GW-1:0]   pick_next;
  logic            pick_valid;
  logic            in_busy;
  logic            owner_valid;
  logic            complete;
  logic            timeout;
  logic            respond;

  logic [WS-1:0]         wstrb_arr [NUM_MASTERS];
  logic [ADDR_WIDTH-1:0] addr_arr  [NUM_MASTERS];
  logic [DATA_WIDTH-1:0] wdata_arr [NUM_MASTERS];

  generate
    for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_master
      assign wstrb_arr[gi]      = m_wstrb[gi*WS +: WS];
      assign addr_arr[gi]       = m_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
      assign wdata_arr[gi]      = m_wdata[gi*DATA_WIDTH +: DATA_WIDTH];
      assign m_ready[gi]        = respond && (grant_reg == GW'(gi));
      // On timeout the fault is forced; otherwise it follows the slave.
      assign m_access_fault[gi] = m_ready[gi] && (timeout || s_access_fault);
    end
  endgenerate

  // Scan last+1, last+2, ... so the previous owner is considered last.
  always_comb begin
    int idx;
    idx        = 0;
    pick_valid = 1'b0;
    pick_next  = last_reg;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      idx = (int'(last_reg) + k) % NUM_MASTERS;
      if (!pick_valid && m_valid[idx]) begin
        pick_valid = 1'b1;
        pick_next  = GW'(idx);
      end
    end
  end

  assign in_busy     = (state_reg == BUSY);
  assign owner_valid = m_valid[grant_reg];
  assign complete    = in_busy && owner_valid && s_ready;
  assign timeout     = (TIMEOUT_CYCLES != 0) && in_busy && owner_valid && !s_ready
                       && (wdog_reg == WDOG_MAX);
  assign respond     = complete || timeout;

  assign s_valid = in_busy && owner_valid && !timeout;
  assign s_wstrb = in_busy ? wstrb_arr[grant_reg] : '0;
  assign s_addr  = in_busy ? addr_arr[grant_reg]  : '0;
  assign s_wdata = in_busy ? wdata_arr[grant_reg] : '0;
  assign m_rdata = timeout ? '0 : s_rdata;
  assign grant   = grant_reg;
  assign busy    = in_busy;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      grant_reg <= '0;
      last_reg  <= LAST_INIT;
      wdog_reg  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (pick_valid) begin
            grant_reg <= pick_next;
            wdog_reg  <= '0;
            state_reg <= BUSY;
          end
        end
        BUSY: begin
          // A withdrawn request abandons ownership without rotating priority.
          if (!owner_valid) begin
            state_reg <= IDLE;
          end else if (respond) begin
            last_reg  <= grant_reg;
            state_reg <= IDLE;
          end else if (wdog_reg != WDOG_MAX) begin
            wdog_reg <= wdog_reg + 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_kianv_mem_arbiter_rr.sv
// Randomized bench for kianv_mem_arbiter_rr: transaction-level round-robin/slave model
// feeds an expected-response queue that a negedge monitor checks against the DUT.
module tb_kianv_mem_arbiter_rr;
  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int WS = DW / 8;
  localparam int TO = 8;
  localparam int GW = 2;
  localparam int NCYC = 4000;

  logic              clk = 1'b0;
  logic              reset;
  logic [N-1:0]      m_valid;
  logic [N-1:0]      m_ready;
  logic [WS*N-1:0]   m_wstrb;
  logic [AW*N-1:0]   m_addr;
  logic [DW*N-1:0]   m_wdata;
  logic [DW-1:0]     m_rdata;
  logic [N-1:0]      m_access_fault;
  logic              s_valid;
  logic              s_ready;
  logic [WS-1:0]     s_wstrb;
  logic [AW-1:0]     s_addr;
  logic [DW-1:0]     s_wdata;
  logic [DW-1:0]     s_rdata;
  logic              s_access_fault;
  logic [GW-1:0]     grant;
  logic              busy;

  always #5 clk = ~clk;

  kianv_mem_arbiter_rr #(
    .NUM_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset),
    .m_valid(m_valid), .m_ready(m_ready), .m_wstrb(m_wstrb), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_rdata(m_rdata), .m_access_fault(m_access_fault),
    .s_valid(s_valid), .s_ready(s_ready), .s_wstrb(s_wstrb), .s_addr(s_addr),
    .s_wdata(s_wdata), .s_rdata(s_rdata), .s_access_fault(s_access_fault),
    .grant(grant), .busy(busy)
  );

  typedef struct {
    int          owner;
    logic [DW-1:0] rdata;
    logic        fault;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  bit   mon_en = 1'b0;

  // Per-cycle expectations published by the stimulus/model side.
  logic          exp_s_valid = 1'b0;
  logic          exp_busy = 1'b0;
  logic [GW-1:0] exp_grant = '0;
  int            exp_owner = 0;

  // Master-side request state.
  logic          pending [N];
  logic          release_m [N];
  logic [AW-1:0] req_addr [N];
  logic [DW-1:0] req_wdata [N];
  logic [WS-1:0] req_wstrb [N];

  // Transaction-level model of the arbiter + slave.
  bit            mdl_busy;
  int            owner, k, lat, last_srv, grant_sh;
  logic [DW-1:0] plan_rdata;
  logic          plan_fault;

  task automatic drive_bus();
    for (int i = 0; i < N; i++) begin
      m_valid[i]             = pending[i];
      m_addr[i*AW +: AW]     = req_addr[i];
      m_wdata[i*DW +: DW]    = req_wdata[i];
      m_wstrb[i*WS +: WS]    = req_wstrb[i];
    end
  endtask

  task automatic push_exp(input int who, input logic [DW-1:0] rd, input logic flt);
    exp_t e;
    e.owner = who;
    e.rdata = rd;
    e.fault = flt;
    e.cyc   = cyc;
    exp_q.push_back(e);
  endtask

  initial begin
    int r;
    int win;
    bit found;
    bit do_rst;
    reset = 1'b1;
    m_valid = '0; m_wstrb = '0; m_addr = '0; m_wdata = '0;
    s_ready = 1'b0; s_rdata = '0; s_access_fault = 1'b0;
    for (int i = 0; i < N; i++) begin
      pending[i] = 1'b0; release_m[i] = 1'b0;
      req_addr[i] = '0; req_wdata[i] = '0; req_wstrb[i] = '0;
    end
    mdl_busy = 1'b0; owner = 0; k = 0; lat = 0; last_srv = N - 1; grant_sh = 0;
    plan_rdata = '0; plan_fault = 1'b0;
    repeat (3) @(posedge clk);
    #1 mon_en = 1'b1;

    for (int t = 0; t < NCYC; t++) begin
      @(posedge clk);
      #1;
      cyc++;
      reset = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (release_m[i]) begin
          pending[i]   = 1'b0;
          release_m[i] = 1'b0;
        end
        if (!pending[i]) begin
          if (t < NCYC - 150 && $urandom_range(0, 3) == 0) begin
            pending[i]   = 1'b1;
            req_addr[i]  = $urandom;
            req_wdata[i] = $urandom;
            req_wstrb[i] = 4'($urandom_range(0, 15));
          end
        end else if ($urandom_range(0, 79) == 0 && !(mdl_busy && owner == i && k == TO + 1)) begin
          pending[i] = 1'b0;
        end
      end
      do_rst = mdl_busy && pending[owner] && (k != lat + 1) && (k <= TO)
               && ($urandom_range(0, 149) == 0);
      drive_bus();
      s_rdata        = $urandom;
      s_access_fault = 1'($urandom_range(0, 1));
      exp_grant      = GW'(grant_sh);
      exp_owner      = owner;

      if (do_rst) begin
        reset       = 1'b1;
        s_ready     = 1'b0;
        exp_busy    = 1'b1;
        exp_s_valid = 1'b1;
        mdl_busy    = 1'b0;
        last_srv    = N - 1;
        grant_sh    = 0;
      end else if (!mdl_busy) begin
        exp_busy    = 1'b0;
        exp_s_valid = 1'b0;
        s_ready     = 1'($urandom_range(0, 1));
        found = 1'b0;
        win   = 0;
        for (int j = 1; j <= N; j++) begin
          if (!found && pending[(last_srv + j) % N]) begin
            found = 1'b1;
            win   = (last_srv + j) % N;
          end
        end
        if (found) begin
          mdl_busy = 1'b1;
          owner    = win;
          grant_sh = win;
          k        = 1;
          r = $urandom_range(0, 9);
          if (r < 7)       lat = $urandom_range(0, 4);
          else if (r == 7) lat = TO;
          else if (r == 8) lat = TO + 1;
          else             lat = 40;
          plan_rdata = $urandom;
          plan_fault = ($urandom_range(0, 5) == 0);
        end
      end else begin
        exp_busy = 1'b1;
        if (!pending[owner]) begin
          s_ready     = 1'b0;
          exp_s_valid = 1'b0;
          mdl_busy    = 1'b0;
        end else if (k == lat + 1) begin
          s_ready        = 1'b1;
          s_rdata        = plan_rdata;
          s_access_fault = plan_fault;
          exp_s_valid    = 1'b1;
          push_exp(owner, plan_rdata, plan_fault);
          last_srv         = owner;
          release_m[owner] = 1'b1;
          mdl_busy         = 1'b0;
        end else if (k == TO + 1) begin
          s_ready     = 1'b0;
          exp_s_valid = 1'b0;
          push_exp(owner, '0, 1'b1);
          last_srv         = owner;
          release_m[owner] = 1'b1;
          mdl_busy         = 1'b0;
        end else begin
          s_ready     = 1'b0;
          exp_s_valid = 1'b1;
          k++;
        end
      end
    end

    @(posedge clk);
    #1 mon_en = 1'b0;
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expected responses never seen, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  always @(negedge clk) begin : monitor
    exp_t e;
    logic [N-1:0] oh;
    if (mon_en) begin
      checks++;
      if (s_valid !== exp_s_valid) begin
        failures++;
        $display("FAIL s_valid cyc=%0d got=%b want=%b", cyc, s_valid, exp_s_valid);
      end
      checks++;
      if (busy !== exp_busy) begin
        failures++;
        $display("FAIL busy cyc=%0d got=%b want=%b", cyc, busy, exp_busy);
      end
      checks++;
      if (grant !== exp_grant) begin
        failures++;
        $display("FAIL grant cyc=%0d got=%0d want=%0d", cyc, grant, exp_grant);
      end
      if (exp_s_valid) begin
        checks++;
        if (s_addr !== req_addr[exp_owner] || s_wdata !== req_wdata[exp_owner]
            || s_wstrb !== req_wstrb[exp_owner]) begin
          failures++;
          $display("FAIL slave_fields cyc=%0d got a=%h d=%h s=%h want a=%h d=%h s=%h",
                   cyc, s_addr, s_wdata, s_wstrb, req_addr[exp_owner],
                   req_wdata[exp_owner], req_wstrb[exp_owner]);
        end
      end
      if (m_ready !== '0) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_ready cyc=%0d got m_ready=%b want 0", cyc, m_ready);
        end else begin
          e  = exp_q.pop_front();
          oh = N'(1) << e.owner;
          $display("txn cyc=%0d master=%0d rdata=%h fault=%b", cyc, e.owner, m_rdata,
                   m_access_fault[e.owner]);
          if (m_ready !== oh || m_access_fault !== (e.fault ? oh : '0)
              || m_rdata !== e.rdata || e.cyc != cyc) begin
            failures++;
            $display("FAIL response cyc=%0d got rdy=%b flt=%b rd=%h want rdy=%b flt=%b rd=%h at cyc=%0d",
                     cyc, m_ready, m_access_fault, m_rdata, oh, (e.fault ? oh : '0),
                     e.rdata, e.cyc);
          end
        end
      end else begin
        checks++;
        if (m_access_fault !== '0) begin
          failures++;
          $display("FAIL stray_fault cyc=%0d got=%b want 0", cyc, m_access_fault);
        end
        if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
          e = exp_q.pop_front();
          checks++;
          failures++;
          $display("FAIL missing_ready cyc=%0d got m_ready=0 want master %0d", cyc, e.owner);
        end
      end
    end
  end

endmodule
